// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares the single-byte uart transmitter between the CPU
// store path (buffered in a small FIFO) and a debug req/ack requester, and
// paces writes so a new byte is only issued once the previous character has
// had CHAR_CYCLES clocks to shift out.
// Build option: define UART_SCHED_DEBUG_PORT_EN to arbitrate the debug port;
// without it the CPU FIFO is the only source and dbg_ack stays low.
//
// state | meaning
// IDLE  | look for a candidate byte, grant and latch it into uart_data
// ISSUE | one-cycle uart_we pulse, load the character timer
// WAIT  | count the character time down to zero, then back to IDLE
module uart_tx_scheduler #(
  parameter int FIFO_DEPTH  = 16,
  parameter int CHAR_CYCLES = 8700
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_we,
  input  logic [7:0]                  cpu_data,
  output logic                        cpu_full,
  input  logic                        dbg_req,
  input  logic [7:0]                  dbg_data,
  output logic                        dbg_ack,
  output logic                        uart_we,
  output logic [7:0]                  uart_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(CHAR_CYCLES);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(CHAR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [TMR_W-1:0]   timer_q;
  logic               fifo_full, fifo_nonempty;
  logic               push_ok, push_drop;
  logic               grant_cpu, grant_dbg;

  assign fifo_full     = (count == FULL_CNT);
  assign fifo_nonempty = (count != '0);
  assign push_ok       = cpu_we && !fifo_full;
  assign push_drop     = cpu_we && fifo_full;
  assign cpu_full      = fifo_full;
  assign fifo_count    = count;

  // FIFO storage; contents are don't-care after reset, only pointers matter
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= cpu_data;
  end

  // FIFO pointers and occupancy; a pop is the CPU grant in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)   wr_ptr <= wr_ptr + 1'b1;
      if (grant_cpu) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, grant_cpu})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // sticky flag for any store dropped because the FIFO was full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           overflow <= 1'b0;
    else if (push_drop) overflow <= 1'b1;
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_cpu || grant_dbg) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (timer_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef UART_SCHED_DEBUG_PORT_EN
  logic last_grant_dbg;

  // grant selection and write strobe; on a tie the source not served last wins
  always_comb begin
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    if (state_q == S_IDLE) begin
      if (fifo_nonempty && (!dbg_req || last_grant_dbg)) grant_cpu = 1'b1;
      else if (dbg_req)                                  grant_dbg = 1'b1;
    end
    uart_we = (state_q == S_ISSUE);
  end

  // round-robin memory; starts at DBG so the CPU wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           last_grant_dbg <= 1'b1;
    else if (grant_cpu) last_grant_dbg <= 1'b0;
    else if (grant_dbg) last_grant_dbg <= 1'b1;
  end

  // ack is combinational from the grant; masked so it reads 0 while in reset
  assign dbg_ack = grant_dbg & rst;
`else
  logic unused_dbg;

  // CPU FIFO is the only source
  always_comb begin
    grant_cpu = (state_q == S_IDLE) && fifo_nonempty;
    grant_dbg = 1'b0;
    uart_we   = (state_q == S_ISSUE);
  end

  assign dbg_ack    = 1'b0;
  assign unused_dbg = ^{dbg_req, dbg_data};
`endif

  // character timer: loaded while issuing, counts down in WAIT, stops at 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    timer_q <= '0;
    else if (state_q == S_ISSUE)                 timer_q <= TMR_RELOAD;
    else if (state_q == S_WAIT && timer_q != '0) timer_q <= timer_q - 1'b1;
  end

  // output byte latched at grant and held until the next grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           uart_data <= 8'h00;
    else if (grant_cpu) uart_data <= mem[rd_ptr];
    else if (grant_dbg) uart_data <= dbg_data;
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios followed by random traffic.
// A cycle-level reference model predicts issued bytes, ack cycles and the
// FIFO status; a monitor compares the DUT against those predictions.
module tb_uart_tx_scheduler;

  localparam int FD = 4;
  localparam int CC = 20;
`ifdef UART_SCHED_DEBUG_PORT_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_we;
  logic [7:0] cpu_data;
  logic       cpu_full;
  logic       dbg_req;
  logic [7:0] dbg_data;
  logic       dbg_ack;
  logic       uart_we;
  logic [7:0] uart_data;
  logic [$clog2(FD):0] fifo_count;
  logic       overflow;

  uart_tx_scheduler #(.FIFO_DEPTH(FD), .CHAR_CYCLES(CC)) dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_data(cpu_data), .cpu_full(cpu_full),
    .dbg_req(dbg_req), .dbg_data(dbg_data), .dbg_ack(dbg_ack),
    .uart_we(uart_we), .uart_data(uart_data),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_uart[$];
  int         exp_ack[$];

  // reference model state: queue of stored bytes, earliest next grant cycle
  logic [7:0] m_q[$];
  int         m_idle_at = 0;
  bit         m_last_dbg = 1'b1;
  bit         m_ovf = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         snap_count;
  bit         snap_ovf;
  logic [7:0] snap_data;
  event       model_done;
  bit         ack_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // model: evaluate cycle cyc from inputs and model state, then apply the edge
  always @(negedge clk) begin : model
    int  sz;
    bit  cpu_c, dbg_c;
    if (!rst) begin
      m_q.delete();
      exp_uart.delete();
      exp_ack.delete();
      m_idle_at  = 0;
      m_last_dbg = 1'b1;
      m_ovf      = 1'b0;
      m_data     = 8'h00;
      snap_count = 0;
      snap_ovf   = 1'b0;
      snap_data  = 8'h00;
    end else begin
      sz         = m_q.size();
      snap_count = sz;
      snap_ovf   = m_ovf;
      snap_data  = m_data;
      if (cyc >= m_idle_at) begin
        cpu_c = (sz > 0);
        dbg_c = DBG_EN && (dbg_req === 1'b1);
        if (cpu_c && (!dbg_c || m_last_dbg)) begin
          m_data = m_q.pop_front();
          exp_uart.push_back('{cyc + 1, m_data});
          m_last_dbg = 1'b0;
          m_idle_at  = cyc + CC + 2;
        end else if (dbg_c) begin
          m_data = dbg_data;
          exp_ack.push_back(cyc);
          exp_uart.push_back('{cyc + 1, m_data});
          m_last_dbg = 1'b1;
          m_idle_at  = cyc + CC + 2;
        end
      end
      if (cpu_we) begin
        if (sz < FD) m_q.push_back(cpu_data);
        else         m_ovf = 1'b1;
      end
    end
    -> model_done;
  end

  // monitor: compare DUT outputs against the model's predictions each cycle
  always begin : monitor
    bit   exp_we, exp_ak;
    exp_t e;
    @(model_done);
    chk("fifo_count", 32'(fifo_count), snap_count);
    chk("cpu_full", 32'(cpu_full), 32'(snap_count == FD));
    chk("overflow", 32'(overflow), 32'(snap_ovf));
    chk("uart_data", 32'(uart_data), 32'(snap_data));
    exp_we = (exp_uart.size() > 0) && (exp_uart[0].cyc == cyc);
    chk("uart_we", 32'(uart_we), 32'(exp_we));
    if (exp_we) e = exp_uart.pop_front();
    exp_ak = (exp_ack.size() > 0) && (exp_ack[0] == cyc);
    chk("dbg_ack", 32'(dbg_ack), 32'(exp_ak));
    if (exp_ak) void'(exp_ack.pop_front());
  end

  task automatic step(input logic we, input logic [7:0] d, input logic raise, input logic [7:0] dd);
    @(posedge clk);
    #1;
    cpu_we   = we;
    cpu_data = d;
    if (dbg_req && ack_seen) dbg_req = 1'b0;
    else if (raise && !dbg_req) begin
      dbg_req  = 1'b1;
      dbg_data = dd;
    end
    @(negedge clk);
    ack_seen = dbg_ack;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    cpu_we   = 1'b0;
    if (DBG_EN) dbg_req = 1'b0;
    ack_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; cpu_we = 1'b0; cpu_data = 8'h00;
    dbg_req = 1'b0; dbg_data = 8'h00; ack_seen = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(8);

    // single CPU bytes, second one must wait a full character slot
    step(1'b1, 8'h41, 1'b0, 8'h00);
    step(1'b1, 8'h42, 1'b0, 8'h00);
    idle(60);

    // six pushes back to back: one in flight, four stored, one dropped
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 8'h00);
    idle(130);

    // tie after reset: CPU, then DBG, then CPU
    do_reset();
    step(1'b1, 8'hA1, 1'b0, 8'h00);
    step(1'b1, 8'hA2, 1'b1, 8'hD0);
    idle(90);

    // debug only
    step(1'b0, 8'h00, 1'b1, 8'h55);
    idle(40);

    // reset while waiting with bytes queued, then silence
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 8'h00);
    idle(6);
    do_reset();
    idle(40);

    // random traffic, light then heavy, with one reset in between
    repeat (1500) step($urandom_range(0, 15) == 0, 8'($urandom), $urandom_range(0, 19) == 0, 8'($urandom));
    do_reset();
    repeat (600) step($urandom_range(0, 1) == 0, 8'($urandom), $urandom_range(0, 9) == 0, 8'($urandom));

    // drain everything still pending
    for (int i = 0; i < 3000 && (exp_uart.size() > 0 || m_q.size() > 0 || (DBG_EN && dbg_req)); i++)
      idle(1);
    idle(2);
    chk("drain_uart_queue", exp_uart.size(), 0);
    chk("drain_fifo_model", m_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Sequences and shares the single-byte `uart` transmitter between two requesters.
- **CPU store path:** bytes from `memory_access`, buffered in an internal FIFO.
- **Debug requester:** single-byte req/ack handshake.

The block sits between `memory_access`, `Debug` and `uart0`. It replaces the direct `uart_we`/`uart_IN_data` connection. It paces writes so a new byte is never issued while the previous character is still shifting out. It raises a back-pressure flag that the controller uses to stall stores.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: CPU byte FIFO entries. Power of two, ≥2.
- `CHAR_CYCLES`, 8700: clk cycles reserved per character (10 bits × 868 clk/bit + margin). Must be ≥2.

Ports:
- `clk` in 1: single clock. All state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_we` in 1: one-cycle push strobe for a CPU store to the UART address.
- `cpu_data` in 8: byte to push.
- `cpu_full` out 1: FIFO full (count == FIFO_DEPTH). Controller stalls stores.
- `dbg_req` in 1: debug byte pending. Held until ack.
- `dbg_data` in 8: debug byte. Stable while `dbg_req`=1.
- `dbg_ack` out 1: one-cycle pulse; byte accepted.
- `uart_we` out 1: one-cycle write pulse to `uart.uart_wr_i`.
- `uart_data` out 8: byte to `uart.uart_dat_i`. Valid while `uart_we`=1.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `overflow` out 1: sticky. Set when a push is dropped.

## Operation
- **FIFO:**
  - Circular buffer with wrapping read/write pointers and a separate count.
  - A push with `cpu_we`=1 and registered count < FIFO_DEPTH writes at the write pointer.
  - A push when full is dropped and sets `overflow`. This holds even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
- **FSM states:** IDLE, ISSUE, WAIT.
  - **IDLE:** candidates are CPU (FIFO non-empty) and DBG (`dbg_req`=1).
    - One candidate: grant it.
    - Both: round-robin. Grant the source not granted last.
    - On grant: latch the byte into `uart_data` (FIFO pop for CPU, `dbg_ack`=1 this cycle for DBG), update `last_grant`, go to ISSUE.
    - No candidate: stay in IDLE.
  - **ISSUE:** `uart_we`=1 for exactly one cycle. Load the counter with CHAR_CYCLES−1. Go to WAIT.
  - **WAIT:** decrement the counter each cycle. At 0, go to IDLE.
- **Counter:** width $clog2(CHAR_CYCLES). Never underflows.
- **`uart_data`:** holds the last issued byte between grants.
- **Reset (asynchronous, any state, mid-character included):**
  - FSM returns to IDLE; FIFO pointers and count go to 0; counter goes to 0; `last_grant`=DBG (so CPU wins the first tie).
  - Outputs: `uart_we`=0, `uart_data`=0, `dbg_ack`=0, `cpu_full`=0, `fifo_count`=0, `overflow`=0.
  - A byte already pulsed to the uart is not recalled.
- **Debug handshake:** `dbg_req` must fall in the cycle after `dbg_ack`. If it stays high, the next request is taken as a new byte.

## Timing
- CPU push at the edge ending cycle N: IDLE grant in N+1, `uart_we` in N+2.
- DBG: `dbg_req` seen in IDLE in cycle M gives `dbg_ack` in M and `uart_we` in M+1.
- Back-to-back issue: successive `uart_we` pulses are exactly CHAR_CYCLES+2 cycles apart (ISSUE + CHAR_CYCLES WAIT + IDLE).
- `cpu_full` and `fifo_count` are registered and update the cycle after the push/pop edge.
- `overflow` rises the cycle after the dropped push.

## Configuration
- `UART_SCHED_DEBUG_PORT_EN`
  - **Defined:** debug requester arbitrated as above.
  - **Undefined:**
    - `dbg_req`/`dbg_data` ignored; `dbg_ack` tied 0.
    - No round-robin state; CPU is the only source.
    - Timing for the CPU path is otherwise identical.
    - Ports remain present.

## Test plan
- **Single CPU byte:** reset, then push 0x41 at cycle 10 → `uart_we`=1 with `uart_data`=0x41 at cycle 12; `fifo_count` 1→0; next `uart_we` never earlier than cycle 12+CHAR_CYCLES+2.
- **FIFO full/overflow** (CHAR_CYCLES=20, FIFO_DEPTH=4): push 6 bytes on consecutive cycles → `cpu_full`=1 once count=4 with one byte in flight; a push while full sets `overflow`=1 sticky; the uart sees exactly 5 bytes in order (one in flight + 4 stored).
- **Tie arbitration:** FIFO non-empty and `dbg_req` with 0xD0 both present in the same IDLE cycle after reset → CPU granted first, then DBG (`dbg_ack` pulse, `uart_data`=0xD0), then CPU again.
- **DBG-only:** `dbg_req` with 0x55 in idle → `dbg_ack` same cycle, `uart_we` next cycle; no further issue after `dbg_req` drops.
- **Reset mid-WAIT:** assert `rst`=0 during WAIT with 3 bytes queued → all outputs reset immediately, `fifo_count`=0; after release, no `uart_we` until a new push.
- **Macro undefined:** hold `dbg_req`=1 permanently → `dbg_ack` stays 0; CPU bytes issue with unchanged timing.
